alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Execute-stage controller that owns the 8-bit ALU. It accepts one operation request at a time over a valid/ready handshake and drives the ALU op, accumulator, operand and status inputs.
- After the ALU latency it captures result and status, then returns them over a valid/ready response channel.
- Wide (16-bit) requests run as two chained 8-bit ALU passes, low byte then high byte; carry propagates through the status byte.

Parameters:
- ALU_LAT, 1, cycles from ALU inputs sampled to result valid on alu_result (legal 1..3).
- N_OPS, 12, number of legal ALU opcodes; req_op >= N_OPS is illegal.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  high only in IDLE
- req_op  in  4  ALU opcode
- req_wide  in  1  1 = 16-bit two-pass operation
- req_a  in  16  accumulator operand; [15:8] ignored when narrow
- req_b  in  16  second operand; [15:8] ignored when narrow
- req_status  in  8  status byte in (C=bit0, Z=bit1, V=bit6, N=bit7)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_result  out  16  result; [15:8]=0 when narrow
- rsp_status  out  8  status out
- rsp_err  out  1  illegal opcode
- op_count  out  8  completed legal operations, wraps 255->0
- alu_op  out  4  to ALU op
- alu_acc  out  8  to ALU accumulator
- alu_opnd  out  8  to ALU operand_2
- alu_status  out  8  to ALU status
- alu_result  in  8  from ALU result
- alu_status_in  in  8  from ALU status_out

Behaviour:
- Reset values (all sync on rst): state=IDLE, req_ready=1, rsp_valid=0, rsp_result=0, rsp_status=0, rsp_err=0, op_count=0, alu_op/alu_acc/alu_opnd/alu_status=0, wait counter=0.
- States: IDLE, EXEC_LO, EXEC_HI, RESP.
- IDLE: on req_valid&req_ready, latch all req_* fields.
  - Legal op -> EXEC_LO.
  - Illegal op -> RESP with rsp_err=1, rsp_result=0, rsp_status=req_status; the ALU-side outputs do not change.
- EXEC_LO:
  - Drive alu_op=op, alu_acc=a[7:0], alu_opnd=b[7:0], alu_status=latched status; hold these stable for the whole state.
  - Stay exactly ALU_LAT+1 cycles, counted by the wait counter.
  - On the final edge, capture alu_result -> lo byte and alu_status_in -> lo status.
  - Then go to EXEC_HI if wide, else RESP.
- EXEC_HI:
  - Drive alu_acc=a[15:8], alu_opnd=b[15:8], alu_status=lo status (carry chaining), same op.
  - Stay ALU_LAT+1 cycles, then capture into hi byte and go to RESP.
- Status rules:
  - Narrow: rsp_status = lo status.
  - Wide: rsp_status = hi status with bit1 (Z) = Zlo & Zhi; all other bits come from the hi pass.
- RESP:
  - rsp_valid=1; rsp_result, rsp_status and rsp_err held stable until rsp_ready.
  - On handshake: -> IDLE, and op_count increments (legal ops only).
  - rsp_valid deasserts the cycle after the handshake.
- Latency from accept edge E0 to rsp_valid first high:
  - Narrow: after edge E0+ALU_LAT+1.
  - Wide: after edge E0+2*(ALU_LAT+1).
  - Illegal op: after edge E0.
- Timing: no overlap; req_ready=0 in EXEC_LO, EXEC_HI and RESP. Earliest new accept is the cycle after the response handshake.
- Request handling: req_valid is ignored outside IDLE. Request fields are sampled only at accept; later changes on req_* have no effect on the running operation.
- rst in any state: next cycle IDLE; the in-flight operation is discarded with no response; ALU outputs and op_count are cleared.
- Opcode 4'd0 is ADC (A+B+C).
- Arithmetic width: each pass is 8-bit. Wide results are mod 2^16 with the final carry reported in rsp_status[0].

Test Plan:
1. Narrow ADC, req_a=66, req_b=30, status=0x00, ALU_LAT=1 -> rsp_result=0x0060, C=0, Z=0, rsp_valid high after E0+2, op_count=1.
2. Wide ADC, 0x01FF+0x0001, C=0 -> lo pass 0x00 with C=1; hi pass gets alu_status bit0=1; rsp_result=0x0200, C=0, Z=0; rsp_valid after E0+4.
3. Wide ADC, 0xFFFF+0x0001, C=0 -> rsp_result=0x0000, C=1, Z=1.
4. Illegal op req_op=12, req_status=0xA5 -> rsp_err=1, rsp_result=0, rsp_status=0xA5 after E0; alu_op unchanged; op_count unchanged.
5. Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> outputs stable, req_ready=0, new req_valid ignored; after handshake op_count increments by exactly 1.
6. Assert rst for 1 cycle during EXEC_HI -> next cycle IDLE, rsp_valid=0, req_ready=1, op_count=0, alu_* outputs=0, no response is ever issued.

Source files
------------

// File: rtl/alu_sequencer.sv
// Execute-stage sequencer for the shared 8-bit ALU.
// Wide requests run as two passes, carry chained through status.
module alu_sequencer #(
  parameter int ALU_LAT = 1,
  parameter int N_OPS   = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic        req_wide,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [7:0]  req_status,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [7:0]  rsp_status,
  output logic        rsp_err,
  output logic [7:0]  op_count,
  output logic [3:0]  alu_op,
  output logic [7:0]  alu_acc,
  output logic [7:0]  alu_opnd,
  output logic [7:0]  alu_status,
  input  logic [7:0]  alu_result,
  input  logic [7:0]  alu_status_in
);

  typedef enum logic [1:0] {
    IDLE, EXEC_LO, EXEC_HI, RESP
  } state_t;

  localparam logic [1:0] LAT_M = 2'(ALU_LAT);
  localparam logic [4:0] NOPS = 5'(N_OPS);

  state_t     state;
  logic       wide_q;
  logic [7:0] a_hi;
  logic [7:0] b_hi;
  logic [7:0] lo_res;
  logic [7:0] lo_st;
  logic [1:0] cnt;
  logic       last;
  logic       legal;

  assign req_ready = (state == IDLE);
  assign last      = (cnt == LAT_M);
  assign legal     = ({1'b0, req_op} < NOPS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wide_q     <= 1'b0;
      a_hi       <= '0;
      b_hi       <= '0;
      lo_res     <= '0;
      lo_st      <= '0;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_status <= '0;
      rsp_err    <= 1'b0;
      op_count   <= '0;
      alu_op     <= '0;
      alu_acc    <= '0;
      alu_opnd   <= '0;
      alu_status <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            wide_q <= req_wide;
            a_hi   <= req_a[15:8];
            b_hi   <= req_b[15:8];
            cnt    <= '0;
            if (legal) begin
              state      <= EXEC_LO;
              alu_op     <= req_op;
              alu_acc    <= req_a[7:0];
              alu_opnd   <= req_b[7:0];
              alu_status <= req_status;
            end else begin
              state      <= RESP;
              rsp_valid  <= 1'b1;
              rsp_err    <= 1'b1;
              rsp_result <= '0;
              rsp_status <= req_status;
            end
          end
        end
        EXEC_LO: begin
          if (last) begin
            cnt    <= '0;
            lo_res <= alu_result;
            lo_st  <= alu_status_in;
            if (wide_q) begin
              state      <= EXEC_HI;
              alu_acc    <= a_hi;
              alu_opnd   <= b_hi;
              alu_status <= alu_status_in;
            end else begin
              state      <= RESP;
              rsp_valid  <= 1'b1;
              rsp_err    <= 1'b0;
              rsp_result <= {8'h00, alu_result};
              rsp_status <= alu_status_in;
            end
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        EXEC_HI: begin
          if (last) begin
            cnt        <= '0;
            state      <= RESP;
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b0;
            rsp_result <= {alu_result, lo_res};
            // Z must reflect the full 16-bit result
            rsp_status <= {alu_status_in[7:2],
                           alu_status_in[1] & lo_st[1],
                           alu_status_in[0]};
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            if (!rsp_err) op_count <= op_count + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural ALU
// and a request-level reference model.
module tb_alu_sequencer;

  localparam int LAT = 1;
  localparam int NOP = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic        req_wide;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [7:0]  req_status;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [7:0]  rsp_status;
  logic        rsp_err;
  logic [7:0]  op_count;
  logic [3:0]  alu_op;
  logic [7:0]  alu_acc;
  logic [7:0]  alu_opnd;
  logic [7:0]  alu_status;
  logic [7:0]  alu_result;
  logic [7:0]  alu_status_in;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic [27:0] snaps[$];

  alu_sequencer #(.ALU_LAT(LAT), .N_OPS(NOP)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_wide(req_wide),
    .req_a(req_a), .req_b(req_b), .req_status(req_status),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_status(rsp_status),
    .rsp_err(rsp_err), .op_count(op_count),
    .alu_op(alu_op), .alu_acc(alu_acc),
    .alu_opnd(alu_opnd), .alu_status(alu_status),
    .alu_result(alu_result), .alu_status_in(alu_status_in)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {status, result}
  function automatic logic [15:0] alu_f(input logic [3:0] op,
                                        input logic [7:0] x, y, s);
    logic [8:0] t;
    logic [7:0] r, o;
    o = s;
    t = '0;
    case (op)
      4'd0: begin
        t = {1'b0, x} + {1'b0, y} + {8'd0, s[0]};
        r = t[7:0]; o[0] = t[8];
        o[6] = (x[7] == y[7]) && (r[7] != x[7]);
      end
      4'd1: begin
        t = {1'b0, x} + {1'b0, ~y} + {8'd0, s[0]};
        r = t[7:0]; o[0] = t[8];
        o[6] = (x[7] != y[7]) && (r[7] != x[7]);
      end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = x + 8'd1;
      4'd6: r = x - 8'd1;
      4'd7: begin r = {x[6:0], 1'b0}; o[0] = x[7]; end
      4'd8: begin r = {1'b0, x[7:1]}; o[0] = x[0]; end
      4'd9: begin r = {x[6:0], s[0]}; o[0] = x[7]; end
      4'd10: begin r = {s[0], x[7:1]}; o[0] = x[0]; end
      4'd11: r = y;
      default: r = 8'hEE;
    endcase
    o[1] = (r == 8'd0);
    o[7] = r[7];
    return {o, r};
  endfunction

  logic [15:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= alu_f(alu_op, alu_acc, alu_opnd, alu_status);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign {alu_status_in, alu_result} = pipe[LAT-1];

  // Request-level reference: {err, status, result}
  function automatic logic [24:0] ref_op(input logic [3:0] op,
                                         input logic w,
                                         input logic [15:0] a, b,
                                         input logic [7:0] st);
    logic [15:0] lo, hi;
    logic [7:0] s;
    if (int'(op) >= NOP) return {1'b1, st, 16'h0000};
    lo = alu_f(op, a[7:0], b[7:0], st);
    if (!w) return {1'b0, lo[15:8], 8'h00, lo[7:0]};
    hi = alu_f(op, a[15:8], b[15:8], lo[15:8]);
    s = hi[15:8];
    s[1] = hi[9] & lo[9];
    return {1'b0, s, hi[7:0], lo[7:0]};
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic w);
    if (int'(op) >= NOP) return 0;
    return w ? 2 * (LAT + 1) : LAT + 1;
  endfunction

  // Issue one request and run to the first cycle of rsp_valid.
  task automatic run_op(input logic [3:0] op, input logic w,
                        input logic [15:0] a, b, input logic [7:0] st,
                        output int lat, output int busy_bad);
    int k;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_wide = w;
    req_a = a; req_b = b; req_status = st;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'($urandom_range(0, 1));
    req_op = 4'($urandom); req_wide = 1'($urandom);
    req_a = 16'($urandom); req_b = 16'($urandom);
    req_status = 8'($urandom);
    snaps.delete();
    busy_bad = 0;
    k = 0;
    while (!rsp_valid && k < 64) begin
      snaps.push_back({alu_op, alu_acc, alu_opnd, alu_status});
      if (req_ready) busy_bad++;
      @(negedge clk);
      k++;
    end
    if (req_ready) busy_bad++;
    checks++;
    if (k >= 64) begin
      errors++;
      $display("FAIL rsp_timeout: rsp_valid not seen in %0d cycles, required within %0d", k, 2*(LAT+1));
    end
    lat = k;
  endtask

  task automatic finish_rsp();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({req_ready, rsp_valid, rsp_err} !== 3'b100) begin
      errors++;
      $display("FAIL reset_hs: ready/valid/err=%b required 100", {req_ready, rsp_valid, rsp_err});
    end
    checks++;
    if ({rsp_result, rsp_status, op_count} !== 32'h0) begin
      errors++;
      $display("FAIL reset_rsp: result/status/count=%h required 0", {rsp_result, rsp_status, op_count});
    end
    checks++;
    if ({alu_op, alu_acc, alu_opnd, alu_status} !== 28'h0) begin
      errors++;
      $display("FAIL reset_alu: alu outputs=%h required 0", {alu_op, alu_acc, alu_opnd, alu_status});
    end
  endtask

  task automatic test_narrow_adc();
    int lat, bb;
    run_op(4'd0, 1'b0, 16'd66, 16'd30, 8'h00, lat, bb);
    checks++;
    if (rsp_result !== 16'h0060 || rsp_status !== 8'h00 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL narrow_adc: res=%h st=%h err=%b required 0060 00 0", rsp_result, rsp_status, rsp_err);
    end
    checks++;
    if (lat != LAT + 1) begin
      errors++;
      $display("FAIL narrow_lat: latency=%0d required %0d", lat, LAT + 1);
    end
    checks++;
    if (snaps[0] !== {4'd0, 8'd66, 8'd30, 8'h00} || bb != 0) begin
      errors++;
      $display("FAIL narrow_drive: alu=%h busy_ready=%0d required %h 0", snaps[0], bb, {4'd0, 8'd66, 8'd30, 8'h00});
    end
    finish_rsp();
    exp_cnt++;
    checks++;
    if (rsp_valid !== 1'b0 || op_count !== exp_cnt) begin
      errors++;
      $display("FAIL narrow_done: valid=%b count=%0d required 0 %0d", rsp_valid, op_count, exp_cnt);
    end
  endtask

  task automatic test_wide_adc();
    logic [15:0] av[2] = '{16'h01FF, 16'hFFFF};
    int lat, bb;
    logic [16:0] sum;
    for (int i = 0; i < 2; i++) begin
      sum = {1'b0, av[i]} + 17'd1;
      run_op(4'd0, 1'b1, av[i], 16'h0001, 8'h00, lat, bb);
      checks++;
      if (rsp_result !== sum[15:0] || rsp_status[0] !== sum[16] ||
          rsp_status[1] !== (sum[15:0] == 16'h0)) begin
        errors++;
        $display("FAIL wide_adc%0d: res=%h C=%b Z=%b required %h %b %b", i, rsp_result,
                 rsp_status[0], rsp_status[1], sum[15:0], sum[16], sum[15:0] == 16'h0);
      end
      checks++;
      if (lat != 2 * (LAT + 1)) begin
        errors++;
        $display("FAIL wide_lat%0d: latency=%0d required %0d", i, lat, 2 * (LAT + 1));
      end
      checks++;
      if (snaps[LAT+1] !== {4'd0, av[i][15:8], 8'h00, 8'h03}) begin
        errors++;
        $display("FAIL wide_chain%0d: hi pass alu=%h required %h", i, snaps[LAT+1],
                 {4'd0, av[i][15:8], 8'h00, 8'h03});
      end
      finish_rsp();
      exp_cnt++;
    end
    checks++;
    if (op_count !== exp_cnt) begin
      errors++;
      $display("FAIL wide_count: count=%0d required %0d", op_count, exp_cnt);
    end
  endtask

  task automatic test_illegal();
    int lat, bb;
    run_op(4'd12, 1'b0, 16'h1234, 16'h5678, 8'hA5, lat, bb);
    checks++;
    if (rsp_err !== 1'b1 || rsp_result !== 16'h0 || rsp_status !== 8'hA5 || lat != 0) begin
      errors++;
      $display("FAIL illegal_rsp: err=%b res=%h st=%h lat=%0d required 1 0000 a5 0",
               rsp_err, rsp_result, rsp_status, lat);
    end
    checks++;
    if ({alu_op, alu_acc, alu_opnd, alu_status} !== {4'd0, 8'hFF, 8'h00, 8'h03}) begin
      errors++;
      $display("FAIL illegal_alu: alu=%h required %h", {alu_op, alu_acc, alu_opnd, alu_status},
               {4'd0, 8'hFF, 8'h00, 8'h03});
    end
    finish_rsp();
    checks++;
    if (op_count !== exp_cnt) begin
      errors++;
      $display("FAIL illegal_count: count=%0d required %0d", op_count, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    int lat, bb;
    logic [24:0] e;
    logic [15:0] a, b;
    a = 16'($urandom); b = 16'($urandom);
    e = ref_op(4'd1, 1'b0, a, b, 8'h01);
    run_op(4'd1, 1'b0, a, b, 8'h01, lat, bb);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_op = 4'd2; req_wide = 1'b1;
      req_a = 16'($urandom); req_b = 16'($urandom);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 ||
          {rsp_err, rsp_status, rsp_result} !== e) begin
        errors++;
        $display("FAIL backpressure%0d: v=%b rdy=%b rsp=%h required 1 0 %h", i, rsp_valid,
                 req_ready, {rsp_err, rsp_status, rsp_result}, e);
      end
    end
    finish_rsp();
    exp_cnt++;
    checks++;
    if (op_count !== exp_cnt || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_done: count=%0d valid=%b required %0d 0", op_count, rsp_valid, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bb, k;
    run_op(4'd3, 1'b0, 16'h0011, 16'h0022, 8'h00, lat, bb);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_op = 4'd2; req_wide = 1'b0;
    req_a = 16'h00F0; req_b = 16'h003C; req_status = 8'h00;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_cnt++;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || op_count !== exp_cnt) begin
      errors++;
      $display("FAIL b2b_handshake: v=%b rdy=%b count=%0d required 0 1 %0d", rsp_valid, req_ready,
               op_count, exp_cnt);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 64) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != LAT + 1 || rsp_result !== 16'h0030) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d res=%h required %0d 0030", k, rsp_result, LAT + 1);
    end
    finish_rsp();
    exp_cnt++;
  endtask

  task automatic test_random();
    int lat, bb;
    logic [3:0] op;
    logic w;
    logic [15:0] a, b;
    logic [7:0] st;
    logic [24:0] e;
    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom_range(0, 15));
      w = 1'($urandom);
      a = 16'($urandom); b = 16'($urandom); st = 8'($urandom);
      if ($urandom_range(0, 3) == 0) b = -a;
      e = ref_op(op, w, a, b, st);
      run_op(op, w, a, b, st, lat, bb);
      checks++;
      if ({rsp_err, rsp_status, rsp_result} !== e) begin
        errors++;
        $display("FAIL rand%0d_rsp: op=%0d w=%b rsp=%h required %h", n, op, w,
                 {rsp_err, rsp_status, rsp_result}, e);
      end
      checks++;
      if (lat != exp_lat(op, w) || bb != 0) begin
        errors++;
        $display("FAIL rand%0d_lat: lat=%0d busy_ready=%0d required %0d 0", n, lat, bb, exp_lat(op, w));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      finish_rsp();
      if (!e[24]) exp_cnt++;
      checks++;
      if (op_count !== exp_cnt) begin
        errors++;
        $display("FAIL rand%0d_count: count=%0d required %0d", n, op_count, exp_cnt);
      end
    end
  endtask

  task automatic test_reset_midop();
    int seen;
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd0; req_wide = 1'b1;
    req_a = 16'h1234; req_b = 16'h4321; req_status = 8'h00;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 8'd0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || op_count !== exp_cnt ||
        {alu_op, alu_acc, alu_opnd, alu_status} !== 28'h0) begin
      errors++;
      $display("FAIL midop_reset: v=%b rdy=%b count=%0d alu=%h required 0 1 0 0", rsp_valid,
               req_ready, op_count, {alu_op, alu_acc, alu_opnd, alu_status});
    end
    rsp_ready = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    rsp_ready = 1'b0;
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midop_norsp: response cycles=%0d required 0", seen);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_wide = 1'b0; req_a = '0; req_b = '0; req_status = '0;
    test_reset();
    test_narrow_adc();
    test_wide_adc();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
